// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: checks EXE-stage outcomes against IF predictions and redirects fetch on a mispredict.
// Latency: the training record (BR_*) appears one cycle after resolve. The redirect appears at R+1 at the earliest.
// Backpressure: the redirect is held until Redirect_Ready. Branches resolved while a redirect is pending are ignored.
module branch_resolve_unit #(
  parameter int CNT_W  = 32,
  parameter int HIST_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EXE_Wr,
  input  logic              EXE_Valid,
  input  logic [31:0]       EXE_PC,
  input  logic [1:0]        EXE_BType,
  input  logic              EXE_Taken,
  input  logic [31:0]       EXE_Target,
  input  logic              P_Valid,
  input  logic              P_Hit,
  input  logic              P_Taken,
  input  logic [31:0]       P_Target,
  input  logic [1:0]        P_Count,
  input  logic [HIST_W-1:0] P_History,
  input  logic              DS_InPipe,
  input  logic              Redirect_Ready,
  output logic              BR_Valid,
  output logic [31:0]       BR_PC,
  output logic [31:0]       BR_Target,
  output logic [1:0]        BR_Type,
  output logic [1:0]        BR_Count,
  output logic              BR_Hit,
  output logic              BR_IsTaken,
  output logic [HIST_W-1:0] BR_History,
  output logic              Redirect_Valid,
  output logic [31:0]       Redirect_PC,
  output logic              Flush_Front,
  output logic [CNT_W-1:0]  Cnt_Branch,
  output logic [CNT_W-1:0]  Cnt_Mispred
);

  // Branch type encoding shared with the predictor
  localparam logic [1:0] BIsNone = 2'd0;
  localparam logic [1:0] BIsImme = 2'd1;
  localparam logic [1:0] BIsCall = 2'd2;
  localparam logic [1:0] BIsRetn = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_DS  = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t              state_q;
  logic                br_valid_q;
  logic [31:0]         br_pc_q;
  logic [31:0]         br_target_q;
  logic [1:0]          br_type_q;
  logic [1:0]          br_count_q;
  logic                br_hit_q;
  logic                br_taken_q;
  logic [HIST_W-1:0]   br_hist_q;
  logic                redirect_valid_q;
  logic [31:0]         redirect_pc_q;
  logic [CNT_W-1:0]    cnt_branch_q;
  logic [CNT_W-1:0]    cnt_mispred_q;

  logic                resolve_d;
  logic                mispred_d;
  logic [31:0]         corr_pc_d;
  logic                unused_types;

  // Only a real, advancing branch on the correct path (FSM idle) is resolved
  always_comb begin
    resolve_d = EXE_Wr & EXE_Valid & (EXE_BType != BIsNone) & (state_q == IDLE);
    mispred_d = resolve_d & ((P_Taken != EXE_Taken)
                             | (EXE_Taken & (P_Target != EXE_Target))
                             | (~P_Valid & EXE_Taken));
    corr_pc_d = EXE_Taken ? EXE_Target : (EXE_PC + 32'd8);
  end

  // The other type codes are listed for readability and are not otherwise used
  assign unused_types = (BIsImme != BIsCall) & (BIsRetn != BIsNone);

  // Training record: one-cycle pulse with fields, all zero when idle
  always_ff @(posedge clk) begin
    if (rst || !resolve_d) begin
      br_valid_q  <= 1'b0;
      br_pc_q     <= '0;
      br_target_q <= '0;
      br_type_q   <= '0;
      br_count_q  <= '0;
      br_hit_q    <= 1'b0;
      br_taken_q  <= 1'b0;
      br_hist_q   <= '0;
    end else begin
      br_valid_q  <= 1'b1;
      br_pc_q     <= EXE_PC;
      br_target_q <= EXE_Target;
      br_type_q   <= EXE_BType;
      br_count_q  <= P_Count;
      br_hit_q    <= P_Hit;
      br_taken_q  <= EXE_Taken;
      br_hist_q   <= P_History;
    end
  end

  // Redirect FSM: wait for the delay slot to reach ID, then hold the redirect until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mispred_d) begin
            redirect_pc_q <= corr_pc_d;
            if (DS_InPipe) begin
              state_q          <= REDIRECT;
              redirect_valid_q <= 1'b1;
            end else begin
              state_q          <= WAIT_DS;
            end
          end
        end
        WAIT_DS: begin
          if (DS_InPipe) begin
            state_q          <= REDIRECT;
            redirect_valid_q <= 1'b1;
          end
        end
        REDIRECT: begin
          if (Redirect_Ready) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q          <= IDLE;
          redirect_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Performance counters, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_branch_q  <= '0;
      cnt_mispred_q <= '0;
    end else begin
      if (resolve_d) cnt_branch_q  <= cnt_branch_q + CNT_ONE;
      if (mispred_d) cnt_mispred_q <= cnt_mispred_q + CNT_ONE;
    end
  end

  assign BR_Valid       = br_valid_q;
  assign BR_PC          = br_pc_q;
  assign BR_Target      = br_target_q;
  assign BR_Type        = br_type_q;
  assign BR_Count       = br_count_q;
  assign BR_Hit         = br_hit_q;
  assign BR_IsTaken     = br_taken_q;
  assign BR_History     = br_hist_q;
  assign Redirect_Valid = redirect_valid_q;
  assign Redirect_PC    = redirect_pc_q;
  assign Flush_Front    = redirect_valid_q & Redirect_Ready;
  assign Cnt_Branch     = cnt_branch_q;
  assign Cnt_Mispred    = cnt_mispred_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int HIST_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              EXE_Wr, EXE_Valid, EXE_Taken;
  logic [31:0]       EXE_PC, EXE_Target, P_Target;
  logic [1:0]        EXE_BType, P_Count;
  logic              P_Valid, P_Hit, P_Taken, DS_InPipe, Redirect_Ready;
  logic [HIST_W-1:0] P_History;

  logic              BR_Valid, BR_Hit, BR_IsTaken, Redirect_Valid, Flush_Front;
  logic [31:0]       BR_PC, BR_Target, Redirect_PC;
  logic [1:0]        BR_Type, BR_Count;
  logic [HIST_W-1:0] BR_History;
  logic [31:0]       Cnt_Branch, Cnt_Mispred;

  // Narrow-counter instance for the wrap check, sharing all inputs
  logic              s_BR_Valid, s_BR_Hit, s_BR_IsTaken, s_Redirect_Valid, s_Flush_Front;
  logic [31:0]       s_BR_PC, s_BR_Target, s_Redirect_PC;
  logic [1:0]        s_BR_Type, s_BR_Count;
  logic [HIST_W-1:0] s_BR_History;
  logic [1:0]        s_Cnt_Branch, s_Cnt_Mispred;

  branch_resolve_unit #(.CNT_W(32), .HIST_W(HIST_W)) dut (
    .clk(clk), .rst(rst), .EXE_Wr(EXE_Wr), .EXE_Valid(EXE_Valid), .EXE_PC(EXE_PC),
    .EXE_BType(EXE_BType), .EXE_Taken(EXE_Taken), .EXE_Target(EXE_Target),
    .P_Valid(P_Valid), .P_Hit(P_Hit), .P_Taken(P_Taken), .P_Target(P_Target),
    .P_Count(P_Count), .P_History(P_History), .DS_InPipe(DS_InPipe),
    .Redirect_Ready(Redirect_Ready), .BR_Valid(BR_Valid), .BR_PC(BR_PC),
    .BR_Target(BR_Target), .BR_Type(BR_Type), .BR_Count(BR_Count), .BR_Hit(BR_Hit),
    .BR_IsTaken(BR_IsTaken), .BR_History(BR_History), .Redirect_Valid(Redirect_Valid),
    .Redirect_PC(Redirect_PC), .Flush_Front(Flush_Front), .Cnt_Branch(Cnt_Branch),
    .Cnt_Mispred(Cnt_Mispred)
  );

  branch_resolve_unit #(.CNT_W(2), .HIST_W(HIST_W)) dut_small (
    .clk(clk), .rst(rst), .EXE_Wr(EXE_Wr), .EXE_Valid(EXE_Valid), .EXE_PC(EXE_PC),
    .EXE_BType(EXE_BType), .EXE_Taken(EXE_Taken), .EXE_Target(EXE_Target),
    .P_Valid(P_Valid), .P_Hit(P_Hit), .P_Taken(P_Taken), .P_Target(P_Target),
    .P_Count(P_Count), .P_History(P_History), .DS_InPipe(DS_InPipe),
    .Redirect_Ready(Redirect_Ready), .BR_Valid(s_BR_Valid), .BR_PC(s_BR_PC),
    .BR_Target(s_BR_Target), .BR_Type(s_BR_Type), .BR_Count(s_BR_Count), .BR_Hit(s_BR_Hit),
    .BR_IsTaken(s_BR_IsTaken), .BR_History(s_BR_History), .Redirect_Valid(s_Redirect_Valid),
    .Redirect_PC(s_Redirect_PC), .Flush_Front(s_Flush_Front), .Cnt_Branch(s_Cnt_Branch),
    .Cnt_Mispred(s_Cnt_Mispred)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  btype;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
    logic        pvalid;
    logic        phit;
    logic        ptaken;
    logic [31:0] ptgt;
    logic [1:0]  pcount;
    logic [2:0]  phist;
    logic        exp_res;
    logic        exp_mis;
    logic [31:0] exp_rpc;
  } vec_t;

  vec_t vec [9];
  int   exp_br;
  int   exp_mp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_branch(input logic [1:0] bt, input logic [31:0] pc, input logic tk,
                              input logic [31:0] tgt, input logic pv, input logic ptk,
                              input logic [31:0] ptgt);
    EXE_Wr = 1'b1; EXE_Valid = 1'b1; EXE_BType = bt; EXE_PC = pc;
    EXE_Taken = tk; EXE_Target = tgt; P_Valid = pv; P_Hit = 1'b1;
    P_Taken = ptk; P_Target = ptgt; P_Count = 2'd2; P_History = 3'd1;
  endtask

  initial begin
    // type codes: 0 none, 1 imme, 2 call, 3 retn
    vec[0] = '{2'd1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 32'h200, 2'd3, 3'd5, 1'b1, 1'b0, 32'h0};
    vec[1] = '{2'd1, 32'h100, 1'b1, 32'h180, 1'b1, 1'b0, 1'b0, 32'h0,   2'd1, 3'd2, 1'b1, 1'b1, 32'h180};
    vec[2] = '{2'd1, 32'h100, 1'b0, 32'h180, 1'b1, 1'b1, 1'b1, 32'h180, 2'd2, 3'd7, 1'b1, 1'b1, 32'h108};
    vec[3] = '{2'd2, 32'h400, 1'b1, 32'h800, 1'b1, 1'b1, 1'b1, 32'h804, 2'd3, 3'd3, 1'b1, 1'b1, 32'h800};
    vec[4] = '{2'd3, 32'h500, 1'b1, 32'h900, 1'b0, 1'b0, 1'b1, 32'h900, 2'd0, 3'd4, 1'b1, 1'b1, 32'h900};
    vec[5] = '{2'd0, 32'h600, 1'b1, 32'h700, 1'b1, 1'b1, 1'b0, 32'h0,   2'd1, 3'd6, 1'b0, 1'b0, 32'h0};
    vec[6] = '{2'd1, 32'hFFFF_FFFC, 1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 32'h0, 2'd0, 3'd0, 1'b1, 1'b0, 32'h0};
    vec[7] = '{2'd1, 32'hFFFF_FFFC, 1'b0, 32'h40, 1'b1, 1'b1, 1'b1, 32'h40, 2'd2, 3'd1, 1'b1, 1'b1, 32'h4};
    vec[8] = '{2'd1, 32'h300, 1'b0, 32'h380, 1'b0, 1'b0, 1'b0, 32'h0,   2'd1, 3'd2, 1'b1, 1'b0, 32'h0};

    rst = 1'b1; EXE_Wr = 0; EXE_Valid = 0; EXE_PC = 0; EXE_BType = 0; EXE_Taken = 0;
    EXE_Target = 0; P_Valid = 0; P_Hit = 0; P_Taken = 0; P_Target = 0; P_Count = 0;
    P_History = 0; DS_InPipe = 0; Redirect_Ready = 0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_br_valid", {31'd0, BR_Valid}, 32'd0);
    check("rst_redir_valid", {31'd0, Redirect_Valid}, 32'd0);
    check("rst_redir_pc", Redirect_PC, 32'd0);
    check("rst_cnt_branch", Cnt_Branch, 32'd0);
    check("rst_cnt_mispred", Cnt_Mispred, 32'd0);

    // Table-driven single-branch vectors, DS already in pipe, redirect accepted at once
    exp_br = 0; exp_mp = 0;
    DS_InPipe = 1'b1; Redirect_Ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      EXE_Wr = 1'b1; EXE_Valid = 1'b1; EXE_BType = vec[i].btype; EXE_PC = vec[i].pc;
      EXE_Taken = vec[i].taken; EXE_Target = vec[i].tgt; P_Valid = vec[i].pvalid;
      P_Hit = vec[i].phit; P_Taken = vec[i].ptaken; P_Target = vec[i].ptgt;
      P_Count = vec[i].pcount; P_History = vec[i].phist;
      step();
      EXE_Wr = 1'b0;
      if (vec[i].exp_res) exp_br++;
      if (vec[i].exp_mis) exp_mp++;
      check($sformatf("v%0d_br_valid", i), {31'd0, BR_Valid}, {31'd0, vec[i].exp_res});
      if (vec[i].exp_res) begin
        check($sformatf("v%0d_br_pc", i), BR_PC, vec[i].pc);
        check($sformatf("v%0d_br_target", i), BR_Target, vec[i].tgt);
        check($sformatf("v%0d_br_fields", i),
              {24'd0, BR_Type, BR_Count, BR_Hit, BR_IsTaken, BR_History[1:0]},
              {24'd0, vec[i].btype, vec[i].pcount, vec[i].phit, vec[i].taken, vec[i].phist[1:0]});
        check($sformatf("v%0d_br_hist", i), {29'd0, BR_History}, {29'd0, vec[i].phist});
      end else begin
        check($sformatf("v%0d_br_pc_zero", i), BR_PC, 32'd0);
      end
      check($sformatf("v%0d_redir_valid", i), {31'd0, Redirect_Valid}, {31'd0, vec[i].exp_mis});
      check($sformatf("v%0d_flush", i), {31'd0, Flush_Front}, {31'd0, vec[i].exp_mis});
      if (vec[i].exp_mis) check($sformatf("v%0d_redir_pc", i), Redirect_PC, vec[i].exp_rpc);
      check($sformatf("v%0d_cnt_branch", i), Cnt_Branch, exp_br);
      check($sformatf("v%0d_cnt_mispred", i), Cnt_Mispred, exp_mp);
      step();
      check($sformatf("v%0d_br_pulse_end", i), {31'd0, BR_Valid}, 32'd0);
      check($sformatf("v%0d_redir_done", i), {31'd0, Redirect_Valid}, 32'd0);
    end

    // Delay slot not yet in ID: WAIT_DS holds for 3 cycles
    DS_InPipe = 1'b0; Redirect_Ready = 1'b0;
    drive_branch(2'd1, 32'h100, 1'b0, 32'h180, 1'b1, 1'b1, 32'h180);
    step();
    EXE_Wr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("wait_ds%0d_redir_valid", c), {31'd0, Redirect_Valid}, 32'd0);
      step();
    end
    DS_InPipe = 1'b1;
    step();
    check("wait_ds_redir_valid", {31'd0, Redirect_Valid}, 32'd1);
    check("wait_ds_redir_pc", Redirect_PC, 32'h108);
    check("wait_ds_no_flush", {31'd0, Flush_Front}, 32'd0);

    // Redirect stalled 4 cycles, wrong-path branch in EXE must be ignored
    drive_branch(2'd1, 32'h2000, 1'b1, 32'h3000, 1'b1, 1'b0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("stall%0d_redir_pc", c), Redirect_PC, 32'h108);
      check($sformatf("stall%0d_redir_valid", c), {31'd0, Redirect_Valid}, 32'd1);
      check($sformatf("stall%0d_br_valid", c), {31'd0, BR_Valid}, 32'd0);
      check($sformatf("stall%0d_cnt_branch", c), Cnt_Branch, exp_br + 1);
    end
    EXE_Wr = 1'b0;
    Redirect_Ready = 1'b1;
    #1;
    check("accept_flush", {31'd0, Flush_Front}, 32'd1);
    step();
    check("accept_redir_valid", {31'd0, Redirect_Valid}, 32'd0);
    check("accept_cnt_mispred", Cnt_Mispred, exp_mp + 1);

    // Reset while in REDIRECT drops the pending redirect and clears counters
    Redirect_Ready = 1'b0;
    drive_branch(2'd1, 32'h100, 1'b1, 32'h180, 1'b1, 1'b0, 32'h0);
    step();
    EXE_Wr = 1'b0;
    check("pre_rst_redir_valid", {31'd0, Redirect_Valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_redir_valid", {31'd0, Redirect_Valid}, 32'd0);
    check("mid_rst_redir_pc", Redirect_PC, 32'd0);
    check("mid_rst_cnt_branch", Cnt_Branch, 32'd0);
    check("mid_rst_cnt_mispred", Cnt_Mispred, 32'd0);
    check("mid_rst_br_valid", {31'd0, BR_Valid}, 32'd0);

    // After reset the unit is IDLE: correct branches resolve; narrow counter wraps
    for (int k = 1; k <= 4; k++) begin
      drive_branch(2'd1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200);
      step();
      EXE_Wr = 1'b0;
      check($sformatf("post_rst%0d_br_valid", k), {31'd0, BR_Valid}, 32'd1);
      check($sformatf("post_rst%0d_cnt_branch", k), Cnt_Branch, k);
      check($sformatf("wrap%0d_small_cnt", k), {30'd0, s_Cnt_Branch}, (k == 4) ? 32'd0 : k);
      check($sformatf("post_rst%0d_redir", k), {31'd0, Redirect_Valid}, 32'd0);
    end
    check("final_cnt_mispred", Cnt_Mispred, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
